mac_unit: RTL and testbench
===========================

MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; accumulator width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port clr, input, 1, closes the current accumulation and starts a new one.
REQ-005 SHALL have port layer_en, input, 1, enables accumulation of pix*ker.
REQ-006 SHALL have port pix, input, WIDTH, signed two's-complement Q1.15 pixel.
REQ-007 SHALL have port ker, input, WIDTH, signed two's-complement Q1.15 kernel weight.
REQ-008 SHALL have port bias, input, 2*WIDTH, signed bias in Q2.30 accumulator format.
REQ-009 SHALL have port mul_out, output, 2*WIDTH, registered running accumulator.
REQ-010 SHALL have port ofm, output, WIDTH, registered quantized biased result.
REQ-011 SHALL have port ofm_valid, output, 1, one-cycle pulse marking a new ofm.

Function
REQ-012 SHALL compute prod = signed pix * signed ker as a full 2*WIDTH-bit signed value.
REQ-013 SHALL, with clr=1 and layer_en=1, load mul_out <= prod; the first term of the new sum is taken in the clr cycle.
REQ-014 SHALL, with clr=1 and layer_en=0, load mul_out <= 0.
REQ-015 SHALL, with clr=0 and layer_en=1, update mul_out <= mul_out + prod.
REQ-016 SHALL, with clr=0 and layer_en=0, hold mul_out.
REQ-017 SHALL, in every cycle with clr=1 regardless of layer_en, compute s = mul_out (value before the update) + bias and register ofm <= {s[2*WIDTH-1], s[2*WIDTH-3:WIDTH-1]}; for WIDTH=16 this is {s[31], s[29:15]}.
REQ-018 SHALL hold ofm in cycles with clr=0.
REQ-019 SHALL register ofm_valid <= clr, so ofm_valid is high in the cycle after each clr and aligned with the new ofm.
REQ-020 SHALL have a latency of 1 clock from the last accumulated term to its presence in mul_out, and 1 clock from clr to ofm/ofm_valid.
REQ-021 SHALL treat back-to-back clr cycles as single-term accumulations, each producing one ofm.

Reset
REQ-022 SHALL have rst_n low override clr and layer_en, setting mul_out=0, ofm=0 and ofm_valid=0 on the next rising edge.
REQ-023 SHALL make a reset asserted mid-accumulation discard the partial sum and produce no ofm_valid in that cycle.
REQ-024 SHALL resume normal operation from the first rising edge with rst_n high.

Configuration
REQ-025 SHALL, when macro MAC_UNIT_SAT_EN is defined, saturate the accumulate and the bias add (REQ-015, REQ-017) to [-2^(2W-1), 2^(2W-1)-1].
REQ-026 SHALL, when MAC_UNIT_SAT_EN is undefined, wrap those additions modulo 2^(2W).
REQ-027 SHALL keep all ports, latency and the quantization bit selection identical in both configurations.

Verification
REQ-028 SHALL cover this scenario: rst_n=0 for 2 cycles, then release -> mul_out=0x00000000, ofm=0x0000, ofm_valid=0.
REQ-029 SHALL cover this scenario: clr=1 then 1 cycle clr=0, both with layer_en=1, pix=ker=0x4000, then clr=1 with bias=0 -> mul_out=0x20000000 before the final clr; ofm=0x4000 with ofm_valid=1 one cycle after the final clr.
REQ-030 SHALL cover this scenario: one clr cycle with pix=0xC000, ker=0x4000, then clr with bias=0 -> mul_out=0xF0000000; ofm=0xE000.
REQ-031 SHALL cover this scenario: layer_en=0 for 5 cycles after accumulating 0x10000000 -> mul_out stays 0x10000000; with bias=0x10000000 the next clr gives ofm=0x4000.
REQ-032 SHALL cover this scenario: pix=ker=0x8000 accumulated twice -> mul_out=0x7FFFFFFF with MAC_UNIT_SAT_EN; mul_out=0x80000000 without it.
REQ-033 SHALL cover this scenario: rst_n=0 for one cycle during accumulation -> mul_out=0 on the next cycle; the next clr yields ofm from the new sum only.

Source files
------------

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with clear-and-dump: each clr closes the running sum, adds bias,
// quantizes to Q1.15 on ofm, and starts the next sum. Define MAC_UNIT_SAT_EN to saturate adds.
module mac_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 layer_en,
    input  logic [WIDTH-1:0]     pix,
    input  logic [WIDTH-1:0]     ker,
    input  logic [2*WIDTH-1:0]   bias,
    output logic [2*WIDTH-1:0]   mul_out,
    output logic [WIDTH-1:0]     ofm,
    output logic                 ofm_valid
);

    localparam int AW = 2 * WIDTH;

    logic [AW-1:0]    mul_out_q, mul_out_d;
    logic [WIDTH-1:0] ofm_q, ofm_d;
    logic             ofm_valid_q, ofm_valid_d;
    logic [AW-1:0]    prod;

    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef MAC_UNIT_SAT_EN
        logic [AW:0] full;
        full = {a[AW-1], a} + {b[AW-1], b};
        // Sign bits disagree only when the true sum left the 2W-bit range.
        if (full[AW] != full[AW-1])
            return full[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return full[AW-1:0];
`else
        return a + b;
`endif
    endfunction

    assign prod = AW'($signed(pix) * $signed(ker));

    always_comb begin
        logic [AW-1:0] s;
        mul_out_d   = mul_out_q;
        ofm_d       = ofm_q;
        ofm_valid_d = clr;
        s           = acc_add(mul_out_q, bias);
        if (clr) begin
            ofm_d     = {s[AW-1], s[AW-3:WIDTH-1]};
            mul_out_d = layer_en ? prod : '0;
        end else if (layer_en) begin
            mul_out_d = acc_add(mul_out_q, prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_out_q   <= '0;
            ofm_q       <= '0;
            ofm_valid_q <= 1'b0;
        end else begin
            mul_out_q   <= mul_out_d;
            ofm_q       <= ofm_d;
            ofm_valid_q <= ofm_valid_d;
        end
    end

    assign mul_out   = mul_out_q;
    assign ofm       = ofm_q;
    assign ofm_valid = ofm_valid_q;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed scenarios plus random traffic against an
// integer-arithmetic reference model of the accumulate / bias / quantize behaviour.
module tb_mac_unit;

    logic        clk = 1'b0;
    logic        rst_n, clr, layer_en;
    logic [15:0] pix, ker, ofm;
    logic [31:0] bias, mul_out;
    logic        ofm_valid;

    int n_vec = 0;
    int n_err = 0;

    longint      m_acc;
    logic [15:0] m_ofm;
    logic        m_v;

    mac_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .layer_en(layer_en),
        .pix(pix), .ker(ker), .bias(bias),
        .mul_out(mul_out), .ofm(ofm), .ofm_valid(ofm_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint to_s32(input logic [31:0] v);
        logic signed [31:0] sv;
        sv = v;
        return longint'(sv);
    endfunction

    function automatic longint to_s16(input logic [15:0] v);
        logic signed [15:0] sv;
        sv = v;
        return longint'(sv);
    endfunction

    // Reference 32-bit signed addition: clamp or wrap depending on configuration.
    function automatic longint ref_add(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef MAC_UNIT_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        s = s % 64'sd4294967296;
        if (s >= 64'sd2147483648) s -= 64'sd4294967296;
        if (s < -64'sd2147483648) s += 64'sd4294967296;
`endif
        return s;
    endfunction

    function automatic logic [15:0] ref_quant(input longint s);
        logic [31:0] v;
        v = s[31:0];
        return {v[31], v[29:15]};
    endfunction

    task automatic cyc(input logic r, input logic c, input logic le,
                       input logic [15:0] p, input logic [15:0] k, input logic [31:0] b);
        longint prod;
        rst_n = r; clr = c; layer_en = le; pix = p; ker = k; bias = b;
        @(posedge clk);
        #1;
        prod = to_s16(p) * to_s16(k);
        if (!r) begin
            m_acc = 0; m_ofm = '0; m_v = 1'b0;
        end else begin
            m_v = c;
            if (c) begin
                m_ofm = ref_quant(ref_add(m_acc, to_s32(b)));
                m_acc = le ? prod : 0;
            end else if (le) begin
                m_acc = ref_add(m_acc, prod);
            end
        end
        check("mul_out", mul_out, m_acc[31:0]);
        check("ofm", {16'h0, ofm}, {16'h0, m_ofm});
        check("ofm_valid", {31'h0, ofm_valid}, {31'h0, m_v});
    endtask

    initial begin
        m_acc = 0; m_ofm = '0; m_v = 1'b0;

        // Reset for two cycles
        cyc(0, 1, 1, 16'h1234, 16'h5678, 32'h1);
        cyc(0, 1, 1, 16'h1234, 16'h5678, 32'h1);
        check("rst_mul_out", mul_out, 32'h0);
        check("rst_ofm", {16'h0, ofm}, 32'h0);
        check("rst_valid", {31'h0, ofm_valid}, 32'h0);

        // 0.5*0.5 accumulated twice, then dump
        cyc(1, 1, 1, 16'h4000, 16'h4000, 32'h0);
        cyc(1, 0, 1, 16'h4000, 16'h4000, 32'h0);
        check("two_term_acc", mul_out, 32'h20000000);
        cyc(1, 1, 0, 16'h0, 16'h0, 32'h0);
        check("two_term_ofm", {16'h0, ofm}, 32'h4000);
        check("two_term_valid", {31'h0, ofm_valid}, 32'h1);

        // Negative product
        cyc(1, 1, 1, 16'hC000, 16'h4000, 32'h0);
        check("neg_acc", mul_out, 32'hF0000000);
        cyc(1, 1, 0, 16'h0, 16'h0, 32'h0);
        check("neg_ofm", {16'h0, ofm}, 32'hE000);

        // Hold with layer_en low, then dump with bias
        cyc(1, 1, 1, 16'h4000, 16'h4000, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h7FFF, 16'h7FFF, 32'h0);
        check("hold_acc", mul_out, 32'h10000000);
        check("hold_valid", {31'h0, ofm_valid}, 32'h0);
        cyc(1, 1, 0, 16'h0, 16'h0, 32'h10000000);
        check("bias_ofm", {16'h0, ofm}, 32'h4000);

        // Overflow boundary: (-1)*(-1) twice
        cyc(1, 1, 1, 16'h8000, 16'h8000, 32'h0);
        cyc(1, 0, 1, 16'h8000, 16'h8000, 32'h0);
`ifdef MAC_UNIT_SAT_EN
        check("ovf_acc", mul_out, 32'h7FFFFFFF);
`else
        check("ovf_acc", mul_out, 32'h80000000);
`endif

        // Reset mid-accumulation
        cyc(1, 1, 1, 16'h4000, 16'h4000, 32'h0);
        cyc(1, 0, 1, 16'h4000, 16'h4000, 32'h0);
        cyc(0, 1, 1, 16'h4000, 16'h4000, 32'h0);
        check("midrst_acc", mul_out, 32'h0);
        check("midrst_valid", {31'h0, ofm_valid}, 32'h0);
        cyc(1, 0, 1, 16'h2000, 16'h4000, 32'h0);
        cyc(1, 1, 0, 16'h0, 16'h0, 32'h0);
        check("midrst_ofm", {16'h0, ofm}, 32'h1000);

        // Back-to-back clr: single-term sums
        cyc(1, 1, 1, 16'h4000, 16'h2000, 32'h0);
        cyc(1, 1, 1, 16'h1000, 16'h1000, 32'h0);
        check("b2b_ofm1", {16'h0, ofm}, 32'h1000);
        cyc(1, 1, 0, 16'h0, 16'h0, 32'h0);
        check("b2b_ofm2", {16'h0, ofm}, 32'h0200);
        check("b2b_valid", {31'h0, ofm_valid}, 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) != 0),
                16'($urandom), 16'($urandom),
                ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'(int'($urandom_range(0, 65535)) - 32768));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
